// File: rtl/ram_fill.sv
// RAM region initialiser: writes LEN words from BASE, one per clock, either a
// constant or an incrementing pattern, then pulses done (with err on range/abort).
module ram_fill #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 6,
   parameter int DEPTH  = 250
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              mode,
   input  logic              abort,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [DATA_W-1:0] ram_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   state_t            state, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;
   logic              wren_d, err_d;
   logic [ADDR_W:0]   end_addr;

   // One past the last address written; may legitimately equal DEPTH.
   assign end_addr = {1'b0, base_addr} + length;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         ram_addr <= addr_d;
         ram_data <= data_d;
         ram_wren <= wren_d;
         err      <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      len_d   = len_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      addr_d  = ram_addr;
      data_d  = ram_data;
      wren_d  = 1'b0;
      err_d   = err;
      case (state)
         IDLE: begin
            if (start) begin
               len_d  = length;
               mode_d = mode;
               if (end_addr > DEPTH_V) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else if (length == '0) begin
                  state_d = DONE;
               end else begin
                  // Word 0 goes out on the capture edge itself.
                  state_d = WRITE;
                  wren_d  = 1'b1;
                  addr_d  = base_addr;
                  data_d  = fill_data;
                  cnt_d   = (ADDR_W+1)'(1);
               end
            end
         end
         WRITE: begin
            // cnt_q counts words already presented, including this cycle's.
            if (abort || cnt_q == len_q) begin
               state_d = DONE;
               err_d   = abort;
            end else begin
               wren_d = 1'b1;
               addr_d = ram_addr + ADDR_W'(1);
               data_d = mode_q ? ram_data + DATA_W'(1) : ram_data;
               cnt_d  = cnt_q + (ADDR_W+1)'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_ram_fill.sv
// Self-checking bench for ram_fill: directed table, reset/abort sequences and
// randomized requests against a cycle-indexed reference model.
module tb_ram_fill;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 6;
   localparam int DEPTH  = 250;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic [DATA_W-1:0] fill_data = '0;
   logic              mode = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_data;
   logic              busy, done, err;

   int n_chk = 0;
   int n_fail = 0;

   ram_fill #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
      .length(length), .fill_data(fill_data), .mode(mode), .abort(abort),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int base; int len; int fill; int md; int abort_k; int junk_c;
      int exp_nw; int exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: number of words that reach the RAM and whether err is flagged.
   function automatic int model_nw(int base, int len, int abort_k);
      if (base + len > DEPTH) return 0;
      if (abort_k >= 0 && abort_k < len) return abort_k + 1;
      return len;
   endfunction

   function automatic int model_err(int base, int len, int abort_k);
      if (base + len > DEPTH) return 1;
      return (abort_k >= 0 && abort_k < len) ? 1 : 0;
   endfunction

   // abort_k: word index during which abort is held (-1 none);
   // junk_c: cycle after start in which a stray start is pulsed (0 none).
   task automatic run_txn(input vec_t v);
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed, f;
      @(posedge clk); #1;
      base_addr = ADDR_W'(v.base);
      length    = (ADDR_W+1)'(v.len);
      fill_data = DATA_W'(v.fill);
      mode      = v.md[0];
      abort     = 1'b0;
      start     = 1'b1;
      f         = DATA_W'(v.fill);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= v.exp_nw + 2; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         start = (c == v.junk_c);
         if (start) begin
            base_addr = 8'd0;
            length    = 9'd5;
            fill_data = 6'h15;
         end
         abort = (v.abort_k >= 0 && c - 1 == v.abort_k);
         if (c <= v.exp_nw) begin
            ea = ADDR_W'(v.base + c - 1);
            ed = v.md[0] ? f + DATA_W'(c - 1) : f;
            chk($sformatf("wren b%0d c%0d", v.base, c), 32'(ram_wren), 32'd1);
            chk($sformatf("addr b%0d c%0d", v.base, c), 32'(ram_addr), 32'(ea));
            chk($sformatf("data b%0d c%0d", v.base, c), 32'(ram_data), 32'(ed));
         end else begin
            chk($sformatf("wren_lo b%0d c%0d", v.base, c), 32'(ram_wren), 32'd0);
         end
         chk($sformatf("done b%0d c%0d", v.base, c), 32'(done), 32'(c == v.exp_nw + 1));
         chk($sformatf("busy b%0d c%0d", v.base, c), 32'(busy), 32'(c <= v.exp_nw + 1));
         if (c == v.exp_nw + 1)
            chk($sformatf("err b%0d", v.base), 32'(err), 32'(v.exp_err));
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      // Directed table: {base,len,fill,mode,abort_k,junk_c, exp writes, exp err}
      tbl.push_back('{0,   250, 'h00, 0, -1, 0, 250, 0});
      tbl.push_back('{10,  4,   'h3E, 1, -1, 5, 4,   0});
      tbl.push_back('{248, 3,   'h11, 0, -1, 0, 0,   1});
      tbl.push_back('{0,   0,   'h11, 0, -1, 1, 0,   0});
      tbl.push_back('{20,  10,  'h07, 0, 2,  2, 3,   1});
      tbl.push_back('{246, 4,   'h01, 1, -1, 3, 4,   0});
      tbl.push_back('{0,   256, 'h2A, 0, -1, 0, 0,   1});
      tbl.push_back('{249, 1,   'h3F, 1, -1, 0, 1,   0});
      tbl.push_back('{5,   3,   'h20, 1, 2,  0, 3,   1});
      tbl.push_back('{251, 0,   'h00, 0, -1, 0, 0,   1});

      #2;
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_data", 32'(ram_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err",  32'(err), 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;

      foreach (tbl[i]) run_txn(tbl[i]);

      // Reset in the middle of a fill: outputs clear at once, no done pulse.
      @(posedge clk); #1;
      base_addr = 8'd30; length = 9'd20; fill_data = 6'h05; mode = 1'b1; start = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("mid_wren", 32'(ram_wren), 32'd1);
      chk("mid_addr", 32'(ram_addr), 32'd34);
      chk("mid_data", 32'(ram_data), 32'h09);
      #2 resetn = 1'b0;
      #1;
      chk("mrst_addr", 32'(ram_addr), 32'd0);
      chk("mrst_wren", 32'(ram_wren), 32'd0);
      chk("mrst_data", 32'(ram_data), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("mrst_done", 32'(done), 32'd0);
      end
      resetn = 1'b1;
      v = '{40, 6, 'h3C, 1, -1, 0, 6, 0};
      run_txn(v);

      // Randomized requests checked against the model.
      for (int i = 0; i < 40; i++) begin
         v.base    = (i % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 200));
         v.len     = (i % 5 == 0) ? int'($urandom_range(0, 256)) : int'($urandom_range(0, 30));
         v.fill    = int'($urandom_range(0, 63));
         v.md      = int'($urandom_range(0, 1));
         v.abort_k = (v.len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, v.len - 1)) : -1;
         v.exp_nw  = model_nw(v.base, v.len, v.abort_k);
         v.exp_err = model_err(v.base, v.len, v.abort_k);
         v.junk_c  = int'($urandom_range(0, v.exp_nw + 1));
         run_txn(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
